// File: rtl/key_cmd_pkg.sv
// Shared constants and command encoding for the push-button front end.
package key_cmd_pkg;

  localparam int PERIOD_W = 32;

  localparam logic [PERIOD_W-1:0] PERIOD_INIT_DEF = 32'd25_000_000;
  localparam logic [PERIOD_W-1:0] PERIOD_STEP_DEF = 32'd12_500_000;
  localparam logic [PERIOD_W-1:0] PERIOD_MIN_DEF  = 32'd12_500_000;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX_DEF  = 32'd100_000_000;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2,
    CMD_RST  = 2'd3
  } cmd_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchronizer, stable-level debouncer and press-edge detector.
// i_key_n is active-low; o_held/o_press are active-high and registered.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_held,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable_n;
  logic [CW-1:0] r_cnt;
  logic          r_held;
  logic          r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable_n <= 1'b1;
      r_cnt      <= '0;
      r_held     <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      // Any return to the stable level before terminal count restarts the window.
      if (r_sync2 == r_stable_n) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        r_stable_n <= r_sync2;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_held  <= ~r_stable_n;
      r_press <= ~r_stable_n & ~r_held;
    end
  end

  assign o_held  = r_held;
  assign o_press = r_press;

endmodule

// File: rtl/key_cmd_frontend.sv
// Debounced push-button front end producing press pulses and a saturating blink period.
// KEY[0] increments, KEY[1] decrements, KEY[2] restores PERIOD_INIT; lower index wins.
module key_cmd_frontend
  import key_cmd_pkg::*;
#(
  parameter int                  NKEYS           = 3,
  parameter int                  DEBOUNCE_CYCLES = 1000000,
  parameter logic [PERIOD_W-1:0] PERIOD_INIT     = PERIOD_INIT_DEF,
  parameter logic [PERIOD_W-1:0] PERIOD_STEP     = PERIOD_STEP_DEF,
  parameter logic [PERIOD_W-1:0] PERIOD_MIN      = PERIOD_MIN_DEF,
  parameter logic [PERIOD_W-1:0] PERIOD_MAX      = PERIOD_MAX_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NKEYS-1:0]    KEY,
  output logic [NKEYS-1:0]    HELD,
  output logic [NKEYS-1:0]    PRESS,
  output logic [PERIOD_W-1:0] PERIOD,
  output logic                PERIOD_UPD
);

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (CLOCK_50),
      .i_rst  (RESET),
      .i_key_n(KEY[g]),
      .o_held (HELD[g]),
      .o_press(PRESS[g])
    );
  end

  cmd_t                w_cmd;
  logic [PERIOD_W:0]   w_sum;
  logic [PERIOD_W:0]   w_floor;
  logic [PERIOD_W-1:0] w_inc;
  logic [PERIOD_W-1:0] w_dec;
  logic [PERIOD_W-1:0] r_period;
  logic                r_upd;

  always_comb begin
    w_cmd = CMD_NONE;
    if (PRESS[0])      w_cmd = CMD_INC;
    else if (PRESS[1]) w_cmd = CMD_DEC;
    else if (PRESS[2]) w_cmd = CMD_RST;
  end

  // One extra bit keeps the add from wrapping; the decrement is guarded before subtracting.
  assign w_sum   = {1'b0, r_period} + {1'b0, PERIOD_STEP};
  assign w_floor = {1'b0, PERIOD_MIN} + {1'b0, PERIOD_STEP};
  assign w_inc   = (w_sum > {1'b0, PERIOD_MAX}) ? PERIOD_MAX : w_sum[PERIOD_W-1:0];
  assign w_dec   = ({1'b0, r_period} >= w_floor) ? (r_period - PERIOD_STEP) : PERIOD_MIN;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_period <= PERIOD_INIT;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= (w_cmd != CMD_NONE);
      case (w_cmd)
        CMD_INC: r_period <= w_inc;
        CMD_DEC: r_period <= w_dec;
        CMD_RST: r_period <= PERIOD_INIT;
        default: r_period <= r_period;
      endcase
    end
  end

  assign PERIOD     = r_period;
  assign PERIOD_UPD = r_upd;

endmodule
